// File: rtl/palu_seq_if.sv
// palu_seq_if: signal bundle between the palu_seq sequencer and its environment
// (instruction store, palu ALU, start/status). The sequencer uses the master modport.
interface palu_seq_if #(
    parameter int PC_W = 5
);
    logic            start;
    logic [PC_W-1:0] instr_addr;
    logic [15:0]     instr;
    logic [7:0]      alu_a;
    logic [7:0]      alu_b;
    logic [2:0]      alu_sel;
    logic [7:0]      alu_f;
    logic            alu_ovf;
    logic            alu_take_branch;
    logic [7:0]      acc;
    logic            ovf_flag;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        input  start, instr, alu_f, alu_ovf, alu_take_branch,
        output instr_addr, alu_a, alu_b, alu_sel, acc, ovf_flag, busy, done, err
    );

    modport slave (
        output start, instr, alu_f, alu_ovf, alu_take_branch,
        input  instr_addr, alu_a, alu_b, alu_sel, acc, ovf_flag, busy, done, err
    );
endinterface

// File: rtl/palu_seq.sv
// palu_seq: two-cycle (FETCH/EXEC) micro-sequencer with a 4x8 register file driving the palu ALU.
// Optional watchdog abort after 255 executed instructions: define PALU_SEQ_WATCHDOG_EN.
module palu_seq #(
    parameter int PC_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    palu_seq_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0]      OP_ALU  = 2'b00;
    localparam logic [1:0]      OP_LDI  = 2'b01;
    localparam logic [1:0]      OP_HALT = 2'b10;
    localparam logic [1:0]      OP_NOP  = 2'b11;
    localparam logic [2:0]      SEL_ADD = 3'd0;
    localparam logic [PC_W-1:0] PC_ZERO = PC_W'(0);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    state_t          state_r;
    state_t          state_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_s;
    logic [PC_W-1:0] pc_inc_s;

    // Decoded instruction register, captured on the FETCH->EXEC edge
    logic [1:0]      op_r;
    logic [2:0]      sel_r;
    logic [1:0]      rd_r;
    logic [7:0]      imm_r;

    logic [7:0]      rf_r [4];
    logic [7:0]      alu_a_r;
    logic [7:0]      alu_b_r;
    logic [2:0]      alu_sel_r;
    logic            ovf_r;
    logic            ovf_s;
    logic            done_r;
    logic            done_s;
    logic            busy_r;
    logic            wr_en_s;
    logic [7:0]      wr_data_s;
    logic            is_branch_s;
    logic            wdog_trip_s;

    assign pc_inc_s    = pc_r + PC_ONE;
    assign is_branch_s = (sel_r[2:1] == 2'b11);

    // Next-state, PC, writeback and flag decode
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ovf_s     = ovf_r;
        done_s    = 1'b0;
        wr_en_s   = 1'b0;
        wr_data_s = bus.alu_f;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_FETCH;
                    pc_s    = PC_ZERO;
                    ovf_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (wdog_trip_s) begin
                    // Abort leaves PC, registers and flags untouched
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                    case (op_r)
                        OP_ALU: begin
                            if (is_branch_s) begin
                                if (bus.alu_take_branch) begin
                                    pc_s = imm_r[PC_W-1:0];
                                end else begin
                                    pc_s = pc_inc_s;
                                end
                            end else begin
                                wr_en_s   = 1'b1;
                                wr_data_s = bus.alu_f;
                                pc_s      = pc_inc_s;
                                if (sel_r == SEL_ADD) begin
                                    ovf_s = ovf_r | bus.alu_ovf;
                                end else begin
                                    ovf_s = ovf_r;
                                end
                            end
                        end
                        OP_LDI: begin
                            wr_en_s   = 1'b1;
                            wr_data_s = imm_r;
                            pc_s      = pc_inc_s;
                        end
                        OP_HALT: begin
                            state_s = ST_IDLE;
                            done_s  = 1'b1;
                        end
                        OP_NOP: begin
                            pc_s = pc_inc_s;
                        end
                        default: begin
                            pc_s = pc_inc_s;
                        end
                    endcase
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, program counter and sticky/pulse status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= PC_ZERO;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            ovf_r   <= ovf_s;
            done_r  <= done_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // IR capture and ALU operand issue; operands are read from the live instr so they are valid for all of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 2'b00;
            sel_r     <= 3'd0;
            rd_r      <= 2'd0;
            imm_r     <= 8'h00;
            alu_a_r   <= 8'h00;
            alu_b_r   <= 8'h00;
            alu_sel_r <= 3'd0;
        end else if (state_r == ST_FETCH) begin
            op_r  <= bus.instr[15:14];
            sel_r <= bus.instr[13:11];
            rd_r  <= bus.instr[10:9];
            imm_r <= bus.instr[7:0];
            if (bus.instr[15:14] == OP_ALU) begin
                alu_a_r   <= rf_r[bus.instr[8:7]];
                alu_b_r   <= rf_r[bus.instr[6:5]];
                alu_sel_r <= bus.instr[13:11];
            end
        end
    end

    // Register file writeback at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_r[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            rf_r[rd_r] <= wr_data_s;
        end
    end

`ifdef PALU_SEQ_WATCHDOG_EN
    logic [7:0] wdog_r;
    logic       err_r;

    // 255th non-HALT EXEC aborts the program
    assign wdog_trip_s = (state_r == ST_EXEC) && (wdog_r == 8'd254) && (op_r != OP_HALT);

    // Executed-instruction counter and sticky error, both cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= 8'd0;
            err_r  <= 1'b0;
        end else if ((state_r == ST_IDLE) && bus.start) begin
            wdog_r <= 8'd0;
            err_r  <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            wdog_r <= wdog_r + 8'd1;
            if (wdog_trip_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.err = err_r;
`else
    assign wdog_trip_s = 1'b0;
    assign bus.err     = 1'b0;
`endif

    assign bus.instr_addr = pc_r;
    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_sel    = alu_sel_r;
    assign bus.acc        = rf_r[0];
    assign bus.ovf_flag   = ovf_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_palu_seq.sv
// tb_palu_seq: directed programs against palu_seq with a behavioural palu ALU and instruction store.
module tb_palu_seq;
    localparam int CYC_LIMIT = 2000;

    logic clk;
    logic rst_n;
    logic [15:0] imem [32];
    int n_cmp;
    int n_bad;
    logic poison_seen;

    palu_seq_if #(.PC_W(5)) bus ();

    palu_seq #(.PC_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.instr = imem[bus.instr_addr];

    // Reference palu: 0 ADD, 1 NOT b, 2 AND, 3 OR, 4 SHR a, 5 SHL a, 6 BEQ, 7 BNE
    logic [8:0] sum_s;
    always_comb begin
        sum_s               = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_f           = 8'hEE;
        bus.alu_ovf         = 1'b0;
        bus.alu_take_branch = 1'b0;
        case (bus.alu_sel)
            3'd0: begin bus.alu_f = sum_s[7:0]; bus.alu_ovf = sum_s[8]; end
            3'd1: bus.alu_f = ~bus.alu_b;
            3'd2: bus.alu_f = bus.alu_a & bus.alu_b;
            3'd3: bus.alu_f = bus.alu_a | bus.alu_b;
            3'd4: bus.alu_f = bus.alu_a >> 1;
            3'd5: bus.alu_f = bus.alu_a << 1;
            3'd6: bus.alu_take_branch = (bus.alu_a == bus.alu_b);
            default: bus.alu_take_branch = (bus.alu_a != bus.alu_b);
        endcase
    end

    always @(negedge clk) begin
        if (bus.acc == 8'hEE) poison_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_alu(input logic [2:0] sel, input logic [1:0] rd,
                                            input logic [1:0] ra, input logic [1:0] rb,
                                            input logic [4:0] tgt);
        return {2'b00, sel, rd, ra, rb, tgt};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {2'b01, 3'b000, rd, 1'b0, imm};
    endfunction

    localparam logic [15:0] I_HALT = 16'h8000;
    localparam logic [15:0] I_NOP  = 16'hC000;

    task automatic clear_imem();
        for (int i = 0; i < 32; i++) imem[i] = I_HALT;
    endtask

    // Pulse start, return the number of edges after the start-sampling edge until done is seen.
    // mid_start_at > 0 re-asserts start for one cycle after that many edges.
    task automatic run_prog(input int mid_start_at, output int cyc);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < CYC_LIMIT) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (cyc == mid_start_at) bus.start = 1'b1;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_after_done(input string tag);
        @(posedge clk); #1;
        check({tag, ".done_1cyc"}, {31'd0, bus.done}, 32'd0);
        check({tag, ".idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".instr_addr"}, {27'd0, bus.instr_addr}, 32'd0);
        check({tag, ".alu_a"}, {24'd0, bus.alu_a}, 32'd0);
        check({tag, ".alu_b"}, {24'd0, bus.alu_b}, 32'd0);
        check({tag, ".alu_sel"}, {29'd0, bus.alu_sel}, 32'd0);
        check({tag, ".acc"}, {24'd0, bus.acc}, 32'd0);
        check({tag, ".flags"}, {28'd0, bus.ovf_flag, bus.busy, bus.done, bus.err}, 32'd0);
    endtask

    task automatic load_add_prog(input logic [7:0] x, input logic [7:0] y);
        clear_imem();
        imem[0] = enc_ldi(2'd1, x);
        imem[1] = enc_ldi(2'd2, y);
        imem[2] = enc_alu(3'd0, 2'd0, 2'd1, 2'd2, 5'd0);
        imem[3] = I_HALT;
    endtask

    initial begin
        int cyc;
        logic [7:0] op_exp [5];
        logic done_seen;
        n_cmp = 0;
        n_bad = 0;
        poison_seen = 1'b0;
        bus.start = 1'b0;
        rst_n = 1'b0;
        clear_imem();
        op_exp[0] = 8'h28; op_exp[1] = 8'h95; op_exp[2] = 8'hF7; op_exp[3] = 8'h5A; op_exp[4] = 8'h6A;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // ADD without carry
        load_add_prog(8'h53, 8'h94);
        run_prog(0, cyc);
        check("add.cycles", cyc, 32'd8);
        check("add.acc", {24'd0, bus.acc}, 32'hE7);
        check("add.ovf", {31'd0, bus.ovf_flag}, 32'd0);
        check("add.halt_pc", {27'd0, bus.instr_addr}, 32'd3);
        check_after_done("add");

        // ADD with carry sets the sticky flag; next start clears it, registers survive
        load_add_prog(8'hD5, 8'h78);
        run_prog(0, cyc);
        check("addc.cycles", cyc, 32'd8);
        check("addc.acc", {24'd0, bus.acc}, 32'h4D);
        check("addc.ovf", {31'd0, bus.ovf_flag}, 32'd1);
        check_after_done("addc");
        check("addc.ovf_sticky", {31'd0, bus.ovf_flag}, 32'd1);
        clear_imem();
        imem[0] = enc_alu(3'd1, 2'd3, 2'd0, 2'd1, 5'd0);
        imem[1] = enc_alu(3'd2, 2'd0, 2'd3, 2'd2, 5'd0);
        run_prog(0, cyc);
        check("notand.cycles", cyc, 32'd6);
        check("notand.acc", {24'd0, bus.acc}, 32'h28);
        check("notand.ovf", {31'd0, bus.ovf_flag}, 32'd0);

        // Per-op sel 1..5; sel 3 gets a start while busy, sel 5 a start during HALT EXEC
        for (int s = 1; s <= 5; s++) begin
            clear_imem();
            imem[0] = enc_ldi(2'd1, 8'hB5);
            imem[1] = enc_ldi(2'd2, 8'hD7);
            imem[2] = enc_alu(3'(s), 2'd0, 2'd1, 2'd2, 5'd0);
            run_prog((s == 3) ? 3 : ((s == 5) ? 7 : 0), cyc);
            check($sformatf("op%0d.cycles", s), cyc, 32'd8);
            check($sformatf("op%0d.acc", s), {24'd0, bus.acc}, {24'd0, op_exp[s-1]});
            check($sformatf("op%0d.issue", s), {13'd0, bus.alu_sel, bus.alu_a, bus.alu_b},
                  {13'd0, 3'(s), 8'hB5, 8'hD7});
            check_after_done($sformatf("op%0d", s));
        end

        // Shift/ADD loop with BNE back-edge, then BEQ over a poison LDI
        clear_imem();
        imem[0]  = enc_ldi(2'd0, 8'h00);
        imem[1]  = enc_ldi(2'd1, 8'h08);
        imem[2]  = enc_ldi(2'd2, 8'h03);
        imem[3]  = enc_ldi(2'd3, 8'h00);
        imem[4]  = enc_alu(3'd0, 2'd0, 2'd0, 2'd2, 5'd0);
        imem[5]  = enc_alu(3'd4, 2'd1, 2'd1, 2'd1, 5'd0);
        imem[6]  = enc_alu(3'd7, 2'd0, 2'd1, 2'd3, 5'd4);
        imem[7]  = enc_alu(3'd6, 2'd0, 2'd3, 2'd3, 5'd9);
        imem[8]  = enc_ldi(2'd0, 8'hEE);
        imem[9]  = enc_alu(3'd5, 2'd0, 2'd0, 2'd0, 5'd0);
        imem[10] = I_HALT;
        poison_seen = 1'b0;
        run_prog(0, cyc);
        check("loop.cycles", cyc, 32'd38);
        check("loop.acc", {24'd0, bus.acc}, 32'h18);
        check("loop.poison", {31'd0, poison_seen}, 32'd0);
        check("loop.halt_pc", {27'd0, bus.instr_addr}, 32'd10);

        // PC wraps 31 -> 0
        clear_imem();
        imem[0] = enc_ldi(2'd0, 8'h00);
        imem[1] = enc_ldi(2'd1, 8'h00);
        run_prog(0, cyc);
        check("wrap_prep.cycles", cyc, 32'd6);
        clear_imem();
        imem[0]  = enc_alu(3'd7, 2'd0, 2'd0, 2'd1, 5'd2);
        imem[1]  = enc_alu(3'd6, 2'd0, 2'd0, 2'd0, 5'd30);
        imem[2]  = enc_ldi(2'd2, 8'hA5);
        imem[30] = enc_ldi(2'd0, 8'h5C);
        imem[31] = I_NOP;
        run_prog(0, cyc);
        check("wrap.cycles", cyc, 32'd14);
        check("wrap.acc", {24'd0, bus.acc}, 32'h5C);
        check("wrap.halt_pc", {27'd0, bus.instr_addr}, 32'd3);

        // Reset during EXEC of the third instruction
        load_add_prog(8'h53, 8'h94);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid.busy", {31'd0, bus.busy}, 32'd1);
        check("rst_mid.alu_a", {24'd0, bus.alu_a}, 32'h53);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) done_seen = 1'b1;
        end
        check("rst_mid.no_done", {31'd0, done_seen}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_prog(0, cyc);
        check("rst_rerun.cycles", cyc, 32'd8);
        check("rst_rerun.acc", {24'd0, bus.acc}, 32'hE7);

        // Self-loop BEQ r0,r0,0
        clear_imem();
        imem[0] = enc_alu(3'd6, 2'd0, 2'd0, 2'd0, 5'd0);
`ifdef PALU_SEQ_WATCHDOG_EN
        run_prog(0, cyc);
        check("wdog.cycles", cyc, 32'd510);
        check("wdog.err", {31'd0, bus.err}, 32'd1);
        check_after_done("wdog");
        check("wdog.err_sticky", {31'd0, bus.err}, 32'd1);
        imem[0] = I_HALT;
        run_prog(0, cyc);
        check("wdog_clear.cycles", cyc, 32'd2);
        check("wdog_clear.err", {31'd0, bus.err}, 32'd0);
`else
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen = 1'b1;
        end
        check("nowdog.busy", {31'd0, bus.busy}, 32'd1);
        check("nowdog.err", {31'd0, bus.err}, 32'd0);
        check("nowdog.no_done", {31'd0, done_seen}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
